// File: rtl/multi_timer_if.sv
// Register bus between the MIPS bridge and multi_timer: word address, single-cycle write,
// combinational read data and interrupt outputs.
interface multi_timer_if #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [31:0]       din;
    logic [31:0]       dout;
    logic [NUM_CH-1:0] irq_vec;
    logic              irq;

    modport master (output addr, output we, output din, input dout, input irq_vec, input irq);
    modport slave  (input addr, input we, input din, output dout, output irq_vec, output irq);
endinterface

// File: rtl/multi_timer.sv
// Multi-channel memory-mapped countdown timer: one-shot/auto-reload, sticky W1C pending, per-channel IRQ.
// Build macro MULTI_TIMER_PRESCALER_EN adds an 8-bit per-channel prescaler programmed through CTRL[15:8].
module multi_timer #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 32,
    parameter int ADDR_W = 5
) (
    input  logic         clk,
    input  logic         reset,
    multi_timer_if.slave bus
);
    localparam int CH_W = ADDR_W - 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_LOAD   = 2'b01,
        ST_CNT    = 2'b10,
        ST_EXPIRE = 2'b11
    } state_e;

    logic [CH_W-1:0]               ch_s;
    logic [1:0]                    reg_s;
    logic [NUM_CH-1:0][31:0]       rd_word_a;
    logic [NUM_CH-1:0]             irq_vec_s;
    logic [31:0]                   dout_s;

    assign ch_s  = bus.addr[ADDR_W-1:2];
    assign reg_s = bus.addr[1:0];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_e           state_r, state_n;
        logic [CNT_W-1:0] count_r, count_n;
        logic [CNT_W-1:0] preset_r, preset_n;
        logic             en_r, en_n;
        logic [1:0]       mode_r, mode_n;
        logic             im_r, im_n;
        logic             pend_r, pend_n;
        logic             sel_s;
        logic             tick_s;
        logic [7:0]       psc_rd_s;
        logic [31:0]      rd_word_s;
`ifdef MULTI_TIMER_PRESCALER_EN
        logic [7:0]       psc_r, psc_n;
        logic [7:0]       pcnt_r, pcnt_n;

        assign tick_s   = (pcnt_r == psc_r);
        assign psc_rd_s = psc_r;
`else
        assign tick_s   = 1'b1;
        assign psc_rd_s = 8'd0;
`endif

        assign sel_s = bus.we && (ch_s == CH_W'(i));

        // Next-state and register-write logic; a write addressed to this channel freezes its FSM for that edge
        always_comb begin
            state_n  = state_r;
            count_n  = count_r;
            preset_n = preset_r;
            en_n     = en_r;
            mode_n   = mode_r;
            im_n     = im_r;
            pend_n   = pend_r;
`ifdef MULTI_TIMER_PRESCALER_EN
            psc_n    = psc_r;
            pcnt_n   = pcnt_r;
`endif
            if (sel_s) begin
                case (reg_s)
                    2'd0: begin
                        en_n   = bus.din[0];
                        mode_n = bus.din[2:1];
                        im_n   = bus.din[3];
`ifdef MULTI_TIMER_PRESCALER_EN
                        psc_n  = bus.din[15:8];
`endif
                    end
                    2'd1: preset_n = bus.din[CNT_W-1:0];
                    2'd3: begin
                        if (bus.din[0]) begin
                            pend_n = 1'b0;
                        end else begin
                            pend_n = pend_r;
                        end
                    end
                    default: count_n = count_r;
                endcase
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (en_r) begin
                            state_n = ST_LOAD;
                        end else begin
                            state_n = ST_IDLE;
                        end
                    end
                    ST_LOAD: begin
                        count_n = preset_r;
                        state_n = ST_CNT;
`ifdef MULTI_TIMER_PRESCALER_EN
                        pcnt_n  = 8'd0;
`endif
                    end
                    ST_CNT: begin
                        if (!en_r) begin
                            state_n = ST_IDLE;
                        end else if (tick_s) begin
`ifdef MULTI_TIMER_PRESCALER_EN
                            pcnt_n = 8'd0;
`endif
                            // A preset of 0 or 1 expires on the first tick, just like a count reaching 1
                            if (count_r > CNT_W'(1)) begin
                                count_n = count_r - CNT_W'(1);
                            end else begin
                                count_n = {CNT_W{1'b0}};
                                pend_n  = 1'b1;
                                state_n = ST_EXPIRE;
                            end
                        end else begin
                            state_n = ST_CNT;
`ifdef MULTI_TIMER_PRESCALER_EN
                            pcnt_n  = pcnt_r + 8'd1;
`endif
                        end
                    end
                    ST_EXPIRE: begin
                        if (mode_r == 2'b00) begin
                            en_n    = 1'b0;
                            state_n = ST_IDLE;
                        end else begin
                            state_n = ST_LOAD;
                        end
                    end
                    default: state_n = ST_IDLE;
                endcase
            end
        end

        // Channel state and register storage
        always_ff @(posedge clk) begin
            if (reset) begin
                state_r  <= ST_IDLE;
                count_r  <= {CNT_W{1'b0}};
                preset_r <= {CNT_W{1'b0}};
                en_r     <= 1'b0;
                mode_r   <= 2'b00;
                im_r     <= 1'b0;
                pend_r   <= 1'b0;
`ifdef MULTI_TIMER_PRESCALER_EN
                psc_r    <= 8'd0;
                pcnt_r   <= 8'd0;
`endif
            end else begin
                state_r  <= state_n;
                count_r  <= count_n;
                preset_r <= preset_n;
                en_r     <= en_n;
                mode_r   <= mode_n;
                im_r     <= im_n;
                pend_r   <= pend_n;
`ifdef MULTI_TIMER_PRESCALER_EN
                psc_r    <= psc_n;
                pcnt_r   <= pcnt_n;
`endif
            end
        end

        // Read view of this channel's registers for the selected register index
        always_comb begin
            case (reg_s)
                2'd0:    rd_word_s = {16'd0, psc_rd_s, 4'd0, im_r, mode_r, en_r};
                2'd1:    rd_word_s = 32'(preset_r);
                2'd2:    rd_word_s = 32'(count_r);
                2'd3:    rd_word_s = {29'd0, state_r, pend_r};
                default: rd_word_s = 32'd0;
            endcase
        end

        assign rd_word_a[i] = rd_word_s;
        assign irq_vec_s[i] = pend_r & im_r;
    end

    // Read mux: only the addressed mapped channel contributes, so unmapped indices read zero
    always_comb begin
        dout_s = 32'd0;
        for (int i = 0; i < NUM_CH; i++) begin
            dout_s = dout_s | (rd_word_a[i] & {32{ch_s == CH_W'(i)}});
        end
    end

    assign bus.dout    = dout_s;
    assign bus.irq_vec = irq_vec_s;
    assign bus.irq     = |irq_vec_s;
endmodule

// File: tb/tb_multi_timer.sv
// Self-checking bench for multi_timer: directed scenarios plus randomized runs against a
// phase-arithmetic reference model of one channel.
module tb_multi_timer;
    localparam int NUM_CH = 2;
    localparam int CNT_W  = 32;
    localparam int ADDR_W = 5;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   nchecks = 0;
    int   nerr    = 0;

    multi_timer_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) bus_if ();

    multi_timer #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] ra(input int ch, input int r);
        return 5'(ch * 4 + r);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int ch, input int r, input logic [31:0] d);
        bus_if.addr = ra(ch, r);
        bus_if.din  = d;
        bus_if.we   = 1'b1;
        @(posedge clk);
        #1;
        bus_if.we   = 1'b0;
    endtask

    task automatic rd(input int ch, input int r, output logic [31:0] d);
        bus_if.addr = ra(ch, r);
        #1;
        d = bus_if.dout;
    endtask

    task automatic do_reset();
        bus_if.we = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Channel behaviour from elapsed non-stalled edges p since the enabling write:
    // p=0 idle, then repeating [LOAD, CNT x max(P,1), EXPIRE]; one-shot ends idle with EN cleared.
    function automatic void model(input int P, input int mode, input int p,
                                  output int st, output int cnt, output int en);
        int p1, len, q;
        p1  = (P == 0) ? 1 : P;
        len = p1 + 2;
        st = 0; cnt = 0; en = 1;
        if (p == 0) begin
            st = 0;
        end else if (mode == 0 && (p - 1) >= len) begin
            st = 0;
            en = 0;
        end else begin
            q = (p - 1) % len;
            if (q == 0) st = 1;
            else if (q <= p1) begin
                st  = 2;
                cnt = P - (q - 1);
            end else st = 3;
        end
    endfunction

    task automatic test_reset();
        logic [31:0] d;
        do_reset();
        for (int ch = 0; ch < 2; ch++) begin
            for (int r = 0; r < 4; r++) begin
                rd(ch, r, d);
                nchecks++;
                if (d !== 32'd0) begin nerr++; $display("FAIL reset_reg ch%0d r%0d got %h want 0", ch, r, d); end
            end
        end
        nchecks++;
        if (bus_if.irq !== 1'b0 || bus_if.irq_vec !== 2'b00) begin
            nerr++; $display("FAIL reset_irq got irq=%b vec=%b want 0/00", bus_if.irq, bus_if.irq_vec);
        end
        wr(5, 0, 32'h9);
        rd(5, 0, d);
        nchecks++;
        if (d !== 32'd0) begin nerr++; $display("FAIL unmapped_read got %h want 0", d); end
        for (int ch = 0; ch < 2; ch++) begin
            rd(ch, 0, d);
            nchecks++;
            if (d !== 32'd0) begin nerr++; $display("FAIL unmapped_write ch%0d ctrl got %h want 0", ch, d); end
        end
    endtask

    task automatic test_oneshot();
        logic [31:0] d;
        do_reset();
        wr(0, 1, 32'd3);
        wr(0, 0, 32'h9);
        tick(); tick();
        rd(0, 2, d);
        nchecks++; if (d !== 32'd3) begin nerr++; $display("FAIL oneshot_e2_count got %0d want 3", d); end
        rd(0, 3, d);
        nchecks++; if (d !== 32'd4) begin nerr++; $display("FAIL oneshot_e2_status got %h want 4", d); end
        tick(); tick(); tick();
        rd(0, 2, d);
        nchecks++; if (d !== 32'd0) begin nerr++; $display("FAIL oneshot_e5_count got %0d want 0", d); end
        rd(0, 3, d);
        nchecks++; if (d !== 32'd7) begin nerr++; $display("FAIL oneshot_e5_status got %h want 7", d); end
        nchecks++; if (bus_if.irq_vec !== 2'b01) begin nerr++; $display("FAIL oneshot_e5_irqvec got %b want 01", bus_if.irq_vec); end
        tick();
        rd(0, 0, d);
        nchecks++; if (d !== 32'h8) begin nerr++; $display("FAIL oneshot_e6_ctrl got %h want 8", d); end
        tick();
        rd(0, 2, d);
        nchecks++; if (d !== 32'd0) begin nerr++; $display("FAIL oneshot_e7_count got %0d want 0", d); end
    endtask

    task automatic test_autoreload();
        logic [31:0] d;
        do_reset();
        wr(1, 1, 32'd2);
        wr(1, 0, 32'hB);
        tick(); tick(); tick();
        nchecks++; if (bus_if.irq !== 1'b0) begin nerr++; $display("FAIL auto_e3_irq got %b want 0", bus_if.irq); end
        tick();
        nchecks++; if (bus_if.irq_vec !== 2'b10) begin nerr++; $display("FAIL auto_e4_irqvec got %b want 10", bus_if.irq_vec); end
        wr(1, 3, 32'h1);
        nchecks++; if (bus_if.irq !== 1'b0) begin nerr++; $display("FAIL auto_w1c_irq got %b want 0", bus_if.irq); end
        tick(); tick();
        rd(1, 2, d);
        nchecks++; if (d !== 32'd2) begin nerr++; $display("FAIL auto_reload_count got %0d want 2", d); end
        tick();
        nchecks++; if (bus_if.irq !== 1'b0) begin nerr++; $display("FAIL auto_e8_irq got %b want 0", bus_if.irq); end
        tick();
        nchecks++; if (bus_if.irq !== 1'b1) begin nerr++; $display("FAIL auto_e9_irq got %b want 1", bus_if.irq); end
    endtask

    task automatic test_isolation();
        logic [31:0] d;
        do_reset();
        wr(0, 1, 32'd100);
        wr(0, 0, 32'h1);
        tick(); tick();
        rd(0, 2, d);
        nchecks++; if (d !== 32'd100) begin nerr++; $display("FAIL iso_start got %0d want 100", d); end
        for (int j = 0; j < 5; j++) begin
            wr(1, 1, $urandom);
            rd(0, 2, d);
            nchecks++;
            if (d !== 32'(99 - j)) begin nerr++; $display("FAIL iso_other_write j%0d got %0d want %0d", j, d, 99 - j); end
        end
        wr(0, 2, 32'hFFFF);
        rd(0, 2, d);
        nchecks++; if (d !== 32'd95) begin nerr++; $display("FAIL iso_count_write got %0d want 95", d); end
        tick();
        rd(0, 2, d);
        nchecks++; if (d !== 32'd94) begin nerr++; $display("FAIL iso_resume got %0d want 94", d); end
    endtask

    task automatic test_masked_and_reset();
        logic [31:0] d;
        do_reset();
        wr(0, 1, 32'd1);
        wr(0, 0, 32'h1);
        tick(); tick(); tick();
        rd(0, 3, d);
        nchecks++; if (d !== 32'd7) begin nerr++; $display("FAIL masked_status got %h want 7", d); end
        nchecks++; if (bus_if.irq !== 1'b0) begin nerr++; $display("FAIL masked_irq got %b want 0", bus_if.irq); end
        tick();
        rd(0, 0, d);
        nchecks++; if (d !== 32'd0) begin nerr++; $display("FAIL masked_ctrl got %h want 0", d); end
        wr(0, 0, 32'h8);
        nchecks++; if (bus_if.irq !== 1'b1 || bus_if.irq_vec !== 2'b01) begin
            nerr++; $display("FAIL unmask_irq got irq=%b vec=%b want 1/01", bus_if.irq, bus_if.irq_vec);
        end
        do_reset();
        wr(0, 1, 32'd60);
        wr(0, 0, 32'h9);
        repeat (12) tick();
        rd(0, 2, d);
        nchecks++; if (d !== 32'd50) begin nerr++; $display("FAIL midreset_pre got %0d want 50", d); end
        bus_if.addr = ra(0, 1);
        bus_if.din  = 32'd5;
        bus_if.we   = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus_if.we = 1'b0;
        for (int r = 0; r < 4; r++) begin
            rd(0, r, d);
            nchecks++;
            if (d !== 32'd0) begin nerr++; $display("FAIL midreset_reg r%0d got %h want 0", r, d); end
        end
        nchecks++; if (bus_if.irq !== 1'b0) begin nerr++; $display("FAIL midreset_irq got %b want 0", bus_if.irq); end
    endtask

    task automatic test_prescaler();
        logic [31:0] d;
        do_reset();
`ifdef MULTI_TIMER_PRESCALER_EN
        wr(0, 1, 32'd2);
        wr(0, 0, 32'h0309);
        rd(0, 0, d);
        nchecks++; if (d !== 32'h0309) begin nerr++; $display("FAIL psc_ctrl got %h want 0309", d); end
        repeat (9) tick();
        nchecks++; if (bus_if.irq !== 1'b0) begin nerr++; $display("FAIL psc_early_irq got %b want 0", bus_if.irq); end
        tick();
        nchecks++; if (bus_if.irq !== 1'b1) begin nerr++; $display("FAIL psc_expire_irq got %b want 1", bus_if.irq); end
`else
        wr(0, 0, 32'h0301);
        rd(0, 0, d);
        nchecks++; if (d !== 32'h1) begin nerr++; $display("FAIL psc_masked_ctrl got %h want 1", d); end
`endif
    endtask

    task automatic test_random();
        for (int t = 0; t < 30; t++) begin
            int c, P, mode, im, p, pend_m, st, cnt, en, act;
            logic [31:0] d;
            logic [1:0]  exp_vec;
            do_reset();
            c    = $urandom_range(0, 1);
            P    = $urandom_range(0, 6);
            mode = $urandom_range(0, 3);
            im   = $urandom_range(0, 1);
            wr(c, 1, 32'(P));
            wr(c, 0, 32'(im * 8 + mode * 2 + 1));
            p = 0;
            pend_m = 0;
            for (int k = 0; k < 24; k++) begin
                model(P, mode, p, st, cnt, en);
                rd(c, 2, d);
                nchecks++;
                if (d !== 32'(cnt)) begin nerr++; $display("FAIL rand_count t%0d k%0d got %0d want %0d", t, k, d, cnt); end
                rd(c, 3, d);
                nchecks++;
                if (d !== 32'(st * 2 + pend_m)) begin nerr++; $display("FAIL rand_status t%0d k%0d got %h want %h", t, k, d, st * 2 + pend_m); end
                rd(c, 0, d);
                nchecks++;
                if (d !== 32'(im * 8 + mode * 2 + en)) begin nerr++; $display("FAIL rand_ctrl t%0d k%0d got %h want %h", t, k, d, im * 8 + mode * 2 + en); end
                exp_vec = 2'((pend_m & im) << c);
                nchecks++;
                if (bus_if.irq_vec !== exp_vec) begin nerr++; $display("FAIL rand_irqvec t%0d k%0d got %b want %b", t, k, bus_if.irq_vec, exp_vec); end
                act = $urandom_range(0, 7);
                case (act)
                    0:       wr(1 - c, 1, $urandom);
                    1:       wr(c, 2, $urandom);
                    2:       wr(c, 3, 32'h1);
                    default: tick();
                endcase
                if (act == 2) begin
                    pend_m = 0;
                end else if (act != 1) begin
                    p++;
                    model(P, mode, p, st, cnt, en);
                    if (st == 3) pend_m = 1;
                end
            end
        end
    endtask

    initial begin
        bus_if.addr = 5'd0;
        bus_if.we   = 1'b0;
        bus_if.din  = 32'd0;
        test_reset();
        test_oneshot();
        test_autoreload();
        test_isolation();
        test_masked_and_reset();
        test_prescaler();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end
endmodule
